decode_stage: RTL and testbench

Parametrised, registered instruction decode stage between fetch and the ALU/issue logic. It slices opcode, ALU op, operand/destination register indices and the predicate index out of each instruction word. It evaluates the predicate against the live predicate file and drops predicated-off instructions. It flags illegal opcodes and buffers decoded results in a small FIFO with valid/ready handshakes on both sides, plus flush and saturating statistics counters.

---
 rtl/decode_stage_pkg.sv | 41 ++++
 rtl/decode_fifo.sv | 75 +++++++
 rtl/decode_stage.sv | 109 ++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode-stage definitions: default field widths, ALU op encodings and
// the decoded-entry layout that travels through the output FIFO.
package decode_stage_pkg;

   localparam int GR_SIZE          = 64;
   localparam int DEF_OPCODE_W     = 8;
   localparam int DEF_ALUOP_W      = 4;
   localparam int DEF_REG_W        = 6;
   localparam int DEF_PRED_W       = 6;
   localparam int DEF_NUM_OPCODES  = 64;

   typedef enum logic [DEF_ALUOP_W-1:0] {
      ALU_ADD = 4'h0,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SHL,
      ALU_SHR,
      ALU_SRA,
      ALU_MUL,
      ALU_CMP
   } aluop_e;

   // Packed order matches the FIFO word built in decode_stage (MSB first).
   typedef struct packed {
      logic [DEF_OPCODE_W-1:0] opcode;
      logic [DEF_ALUOP_W-1:0]  aluop;
      logic [DEF_REG_W-1:0]    src1;
      logic [DEF_REG_W-1:0]    src2;
      logic [DEF_REG_W-1:0]    dest;
      logic [DEF_PRED_W-1:0]   pred;
      logic                    illegal;
   } dec_entry_t;

   function automatic int entry_width(input int opc_w, input int alu_w,
                                      input int reg_w, input int pred_w);
      return opc_w + alu_w + 3 * reg_w + pred_w + 1;
   endfunction

endpackage

// File: rtl/decode_fifo.sv
// Synchronous FIFO of decoded entries with a registered head word, so the
// consumer side never sees a combinational path from the push side.
module decode_fifo #(
   parameter int DATA_W = 37,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

   if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
      $error("decode_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
   logic [PTR_W:0]    occ;
   logic              do_push, do_pop;

   assign full    = (occ == OCC_FULL);
   assign empty   = (occ == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_nxt  = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Head register tracks whatever sits at rd_ptr after this edge; it holds
   // its old value once the FIFO drains or is flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (!flush) begin
         if (do_pop) begin
            if (occ == OCC_ONE) begin
               if (do_push) dout <= din;
            end else begin
               dout <= mem[rd_nxt];
            end
         end else if (do_push && empty) begin
            dout <= din;
         end
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode: slices fields, evaluates the predicate,
// flags illegal opcodes and buffers decoded entries in a small FIFO.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int INSTR_W     = GR_SIZE,
   parameter int OPCODE_W    = DEF_OPCODE_W,
   parameter int ALUOP_W     = DEF_ALUOP_W,
   parameter int REG_W       = DEF_REG_W,
   parameter int PRED_W      = DEF_PRED_W,
   parameter int NUM_OPCODES = DEF_NUM_OPCODES,
   parameter int DEPTH       = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instr,
   input  logic [2**PRED_W-1:0] pred_mask,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OPCODE_W-1:0]  out_opcode,
   output logic [ALUOP_W-1:0]   out_aluop,
   output logic [REG_W-1:0]     out_src1,
   output logic [REG_W-1:0]     out_src2,
   output logic [REG_W-1:0]     out_dest,
   output logic [PRED_W-1:0]    out_pred,
   output logic                 out_illegal,
   output logic [CNT_W-1:0]     decoded_cnt,
   output logic [CNT_W-1:0]     squashed_cnt
);

   localparam int ENT_W   = entry_width(OPCODE_W, ALUOP_W, REG_W, PRED_W);
   localparam int ALU_TOP = INSTR_W - OPCODE_W - 1;
   localparam int S1_TOP  = ALU_TOP - ALUOP_W;
   localparam int S2_TOP  = S1_TOP - REG_W;
   localparam int DST_TOP = S2_TOP - REG_W;
   localparam logic [OPCODE_W:0] NUM_OPC_L = (OPCODE_W+1)'(NUM_OPCODES);

   if (OPCODE_W + ALUOP_W + 3 * REG_W + PRED_W > INSTR_W) begin : g_bad_fields
      $error("decode_stage: instruction fields exceed INSTR_W");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [OPCODE_W-1:0] opc_p0;
   logic [ALUOP_W-1:0]  alu_p0;
   logic [REG_W-1:0]    src1_p0, src2_p0, dest_p0;
   logic [PRED_W-1:0]   pred_p0;
   logic                ill_p0, pred_true_p0;
   logic                accept_p0, push_p0, squash_p0;
   logic [ENT_W-1:0]    ent_p0, head_p1;
   logic                full_p1, empty_p1, vld_p1;
   logic                unused_instr;

   // Stage p0: combinational slice of the incoming word.
   assign opc_p0  = in_instr[INSTR_W-1 -: OPCODE_W];
   assign alu_p0  = in_instr[ALU_TOP -: ALUOP_W];
   assign src1_p0 = in_instr[S1_TOP -: REG_W];
   assign src2_p0 = in_instr[S2_TOP -: REG_W];
   assign dest_p0 = in_instr[DST_TOP -: REG_W];
   assign pred_p0 = in_instr[PRED_W-1:0];
   assign unused_instr = ^in_instr;

   assign ill_p0       = ({1'b0, opc_p0} >= NUM_OPC_L);
   assign pred_true_p0 = (pred_p0 == '0) | pred_mask[pred_p0];
   assign ent_p0       = {opc_p0, alu_p0, src1_p0, src2_p0, dest_p0, pred_p0, ill_p0};

   // in_ready deliberately ignores out_ready to keep the handshake paths separate.
   assign in_ready  = ~full_p1 & ~rst;
   assign accept_p0 = in_valid & in_ready & ~flush;
   assign push_p0   = accept_p0 & pred_true_p0;
   assign squash_p0 = accept_p0 & ~pred_true_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         decoded_cnt  <= '0;
         squashed_cnt <= '0;
      end else begin
         if (push_p0)   decoded_cnt  <= sat_inc(decoded_cnt);
         if (squash_p0) squashed_cnt <= sat_inc(squashed_cnt);
      end
   end

   // Stage p1: FIFO head register.
   decode_fifo #(
      .DATA_W (ENT_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push_p0),
      .pop   (vld_p1 & out_ready),
      .din   (ent_p0),
      .dout  (head_p1),
      .full  (full_p1),
      .empty (empty_p1)
   );

   assign vld_p1    = ~empty_p1;
   assign out_valid = vld_p1;
   assign {out_opcode, out_aluop, out_src1, out_src2, out_dest, out_pred, out_illegal} = head_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected entries are queued on accept
// and compared whenever the DUT hands an entry to the consumer.
module tb_decode_stage;

   typedef logic [36:0] ent_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready, in_ready, out_valid, out_illegal;
   logic [63:0] in_instr, pred_mask;
   logic [7:0]  out_opcode;
   logic [3:0]  out_aluop;
   logic [5:0]  out_src1, out_src2, out_dest, out_pred;
   logic [15:0] decoded_cnt, squashed_cnt;

   logic        s_valid, s_in_ready, s_unused_vld, s_unused_ill;
   logic [63:0] s_instr, s_mask;
   logic [7:0]  s_unused_opc;
   logic [3:0]  s_unused_alu;
   logic [5:0]  s_unused_s1, s_unused_s2, s_unused_d, s_unused_p;
   logic [1:0]  s_dec, s_sq;

   int   checks = 0;
   int   errors = 0;
   int   exp_dec = 0;
   int   exp_sq = 0;
   int   w;
   ent_t sb[$];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .pred_mask(pred_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_aluop(out_aluop), .out_src1(out_src1), .out_src2(out_src2),
      .out_dest(out_dest), .out_pred(out_pred), .out_illegal(out_illegal),
      .decoded_cnt(decoded_cnt), .squashed_cnt(squashed_cnt)
   );

   decode_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(s_valid), .in_ready(s_in_ready),
      .in_instr(s_instr), .pred_mask(s_mask), .out_valid(s_unused_vld), .out_ready(1'b1),
      .out_opcode(s_unused_opc), .out_aluop(s_unused_alu), .out_src1(s_unused_s1),
      .out_src2(s_unused_s2), .out_dest(s_unused_d), .out_pred(s_unused_p),
      .out_illegal(s_unused_ill), .decoded_cnt(s_dec), .squashed_cnt(s_sq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [7:0] op, input logic [3:0] alu,
                                      input logic [5:0] s1, input logic [5:0] s2,
                                      input logic [5:0] d, input logic [5:0] p);
      return {op, alu, s1, s2, d, 28'($urandom), p};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      check({tag, "_decoded"}, 64'(decoded_cnt), 64'(exp_dec));
      check({tag, "_squashed"}, 64'(squashed_cnt), 64'(exp_sq));
   endtask

   // Drives one word until accepted; waited returns the stall cycles seen.
   task automatic send(input logic [7:0] op, input logic [3:0] alu, input logic [5:0] s1,
                       input logic [5:0] s2, input logic [5:0] d, input logic [5:0] p,
                       input logic [63:0] mask, output int waited);
      logic acc;
      logic emit;
      emit      = (p == 6'd0) || mask[p];
      in_instr  = mk(op, alu, s1, s2, d, p);
      pred_mask = mask;
      in_valid  = 1'b1;
      acc       = 1'b0;
      waited    = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         if (!acc) waited++;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      if (!acc) check("send_timeout", 64'd0, 64'd1);
      else if (emit) begin
         sb.push_back({op, alu, s1, s2, d, p, (op >= 8'h40)});
         exp_dec++;
      end else begin
         exp_sq++;
      end
   endtask

   always @(negedge clk) begin : monitor
      ent_t e;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("out_entry", 64'({out_opcode, out_aluop, out_src1, out_src2, out_dest,
                                    out_pred, out_illegal}), 64'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; pred_mask = '0; s_valid = 1'b0; s_instr = '0; s_mask = '0;

      // Reset state
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fields", 64'({out_opcode, out_aluop, out_src1, out_src2, out_dest,
                               out_pred, out_illegal}), 64'd0);
      chk_cnt("rst");
      rst = 1'b0;
      idle(1);

      // Single decode with one-cycle latency
      send(8'h12, 4'd3, 6'd5, 6'd9, 6'd17, 6'd0, 64'd0, w);
      @(negedge clk);
      check("latency_valid", 64'(out_valid), 64'd1);
      chk_cnt("single");
      idle(2);

      // Predicate squash / emit
      send(8'h21, 4'd1, 6'd1, 6'd2, 6'd3, 6'd7, 64'h0, w);
      idle(2);
      @(negedge clk);
      check("squash_no_valid", 64'(out_valid), 64'd0);
      chk_cnt("squash");
      idle(1);
      send(8'h21, 4'd1, 6'd1, 6'd2, 6'd3, 6'd7, 64'h80, w);
      send(8'h22, 4'd2, 6'd4, 6'd5, 6'd6, 6'd0, 64'h0, w);
      send(8'h23, 4'd2, 6'd4, 6'd5, 6'd6, 6'd7, ~64'h80, w);
      idle(3);
      chk_cnt("pred");

      // Backpressure: third word must wait while the FIFO is full
      out_ready = 1'b0;
      send(8'h0A, 4'd1, 6'd1, 6'd1, 6'd1, 6'd0, 64'd0, w);
      send(8'h0B, 4'd2, 6'd2, 6'd2, 6'd2, 6'd0, 64'd0, w);
      in_instr = mk(8'h0C, 4'd3, 6'd3, 6'd3, 6'd3, 6'd0);
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("full_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("full_pop_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      send(8'h0C, 4'd3, 6'd3, 6'd3, 6'd3, 6'd0, 64'd0, w);
      idle(4);
      check("bp_drain", 64'(sb.size()), 64'd0);

      // Back-to-back stream at occupancy 1
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom_range(0, 63)), 4'($urandom), 6'($urandom), 6'($urandom),
              6'($urandom), 6'd0, 64'd0, w);
         check("stream_no_stall", 64'(w), 64'd0);
      end
      idle(3);

      // Illegal opcodes
      send(8'h40, 4'd5, 6'd10, 6'd11, 6'd12, 6'd0, 64'd0, w);
      send(8'h3F, 4'd6, 6'd13, 6'd14, 6'd15, 6'd0, 64'd0, w);
      send(8'hFF, 4'd7, 6'd16, 6'd17, 6'd18, 6'd3, 64'h0, w);
      send(8'hFF, 4'd7, 6'd16, 6'd17, 6'd18, 6'd3, 64'h8, w);
      idle(3);
      chk_cnt("illegal");

      // Flush with a full FIFO and a valid input
      out_ready = 1'b0;
      send(8'h31, 4'd1, 6'd1, 6'd2, 6'd3, 6'd0, 64'd0, w);
      send(8'h32, 4'd1, 6'd1, 6'd2, 6'd3, 6'd0, 64'd0, w);
      in_instr = mk(8'h33, 4'd1, 6'd1, 6'd2, 6'd3, 6'd0);
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      sb.delete(); exp_dec -= 2;
      exp_dec += 2;
      @(negedge clk);
      check("flush_full_valid", 64'(out_valid), 64'd0);
      check("flush_full_ready", 64'(in_ready), 64'd1);
      chk_cnt("flush_full");
      idle(1);
      // Flush with one entry and an input that would otherwise be accepted
      send(8'h34, 4'd1, 6'd1, 6'd2, 6'd3, 6'd0, 64'd0, w);
      in_instr = mk(8'h35, 4'd1, 6'd1, 6'd2, 6'd3, 6'd0);
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_one_valid", 64'(out_valid), 64'd0);
      chk_cnt("flush_one");
      @(posedge clk); #1 out_ready = 1'b1;
      send(8'h15, 4'd9, 6'd21, 6'd22, 6'd23, 6'd0, 64'd0, w);
      idle(3);
      @(negedge clk);
      check("flush_drain", 64'(sb.size()), 64'd0);
      check("hold_opcode", 64'(out_opcode), 64'h15);
      check("hold_valid", 64'(out_valid), 64'd0);
      idle(1);

      // Reset mid-stream discards entries and clears counters
      out_ready = 1'b0;
      send(8'h01, 4'd1, 6'd1, 6'd1, 6'd1, 6'd0, 64'd0, w);
      send(8'h02, 4'd2, 6'd2, 6'd2, 6'd2, 6'd0, 64'd0, w);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_opcode", 64'(out_opcode), 64'd0);
      sb.delete(); exp_dec = 0; exp_sq = 0;
      chk_cnt("midrst");
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      send(8'h2A, 4'd4, 6'd8, 6'd9, 6'd10, 6'd0, 64'd0, w);
      idle(3);
      chk_cnt("post_rst");

      // Saturating counters on the CNT_W=2 instance
      s_mask = 64'd0;
      s_instr = mk(8'h01, 4'd0, 6'd1, 6'd2, 6'd3, 6'd0);
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("sat_in_ready", 64'(s_in_ready), 64'd1);
         @(posedge clk); #1;
      end
      s_instr = mk(8'h01, 4'd0, 6'd1, 6'd2, 6'd3, 6'd5);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      @(negedge clk);
      check("sat_decoded", 64'(s_dec), 64'd3);
      check("sat_squashed", 64'(s_sq), 64'd3);

      idle(2);
      check("final_drain", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
